// File: rtl/dmem_display_scanner.sv
// Scans the 16-word data-memory bus onto a 4-digit multiplexed 7-segment display:
// address on the leftmost digit, a blank, then the byte value in hex.
module dmem_display_scanner #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DWELL       = 25000000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [127:0] mem_flat,
    input  logic         auto_mode,
    input  logic         step,
    input  logic         hold,
    output logic [6:0]   seg,
    output logic [3:0]   an,
    output logic [3:0]   cur_addr,
    output logic         frame_tick
);

    localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DW = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'h7F;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    addr_q, addr_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [7:0]    snap_q, snap_d;
    logic          step_q;
    logic          auto_q;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          frame_q, frame_d;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state: scan counters, address control, frame-coherent snapshot, display drive
    always_comb begin
        logic wrap_c;
        logic adv_c;

        presc_d = presc_q + PW'(1);
        digit_d = digit_q;
        wrap_c  = 1'b0;
        addr_d  = addr_q;
        dwell_d = dwell_q;
        adv_c   = 1'b0;
        snap_d  = snap_q;
        seg_d   = SEG_BLANK;
        an_d    = ~(4'b0001 << digit_q);

        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            digit_d = digit_q + 2'd1;
            wrap_c  = (digit_q == 2'd3);
        end

        // hold outranks auto, auto outranks step; a mode change restarts the dwell
        if (hold) begin
            addr_d  = addr_q;
        end else if (auto_mode) begin
            if (!auto_q) begin
                dwell_d = '0;
            end else if (dwell_q == DWELL_LAST) begin
                dwell_d = '0;
                addr_d  = addr_q + 4'd1;
                adv_c   = 1'b1;
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end else begin
            dwell_d = '0;
            if (step && !step_q) begin
                addr_d = addr_q + 4'd1;
                adv_c  = 1'b1;
            end
        end

        // Byte only captured at frame boundaries or address moves, so no tearing mid-frame
        if (wrap_c || adv_c) begin
            snap_d = mem_flat[{addr_d, 3'b000} +: 8];
        end

        case (digit_q)
            2'd0:    seg_d = hex7(snap_q[3:0]);
            2'd1:    seg_d = hex7(snap_q[7:4]);
            2'd2:    seg_d = SEG_BLANK;
            default: seg_d = hex7(addr_q);
        endcase

        frame_d = wrap_c;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            digit_q <= 2'd0;
            addr_q  <= 4'd0;
            dwell_q <= '0;
            snap_q  <= 8'h00;
            step_q  <= 1'b0;
            auto_q  <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= 4'hF;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            addr_q  <= addr_d;
            dwell_q <= dwell_d;
            snap_q  <= snap_d;
            step_q  <= step;
            auto_q  <= auto_mode;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign cur_addr   = addr_q;
    assign frame_tick = frame_q;

endmodule
